fetch_stage_ctrl: RTL and testbench

Fetch-stage controller that sits directly upstream of the IF/ID latch. It replaces the single-cycle fetch with a PC register, a request/response handshake to a variable-latency instruction memory, and a registered output slot for IF/ID. The slot holds under decode stall and is flushed on a branch/jump redirect from execute. It also detects HALT, stops fetching, and flags misaligned redirect targets.

---
 rtl/fetch_stage_ctrl_if.sv | 30 +++
 rtl/fetch_stage_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_ctrl_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the IF/ID output slot
// and the execute-stage redirect that steers it.
//
// Handshakes: a memory request is accepted on a clock edge where imem_req=1 and
// imem_stall=0. imem_done marks imem_rdata valid for that one cycle. The output
// slot is valid while valid_out=1. Decode consumes it on an edge where id_stall=0.
interface fetch_stage_ctrl_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic [15:0] pc_next_out;
    logic        valid_out;

    modport master (
        output imem_req, imem_addr, instr_out, pc_out, pc_next_out, valid_out,
        input  imem_stall, imem_done, imem_rdata, id_stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, pc_out, pc_next_out, valid_out,
        output imem_stall, imem_done, imem_rdata, id_stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Fetch-stage controller: PC register, variable-latency imem handshake, IF/ID output slot
// with decode-stall hold, redirect flush, HALT detection and misaligned-redirect flag.
module fetch_stage_ctrl #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] PC_INC      = 16'd2,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic                       clk,
    input  logic                       rst,
    fetch_stage_ctrl_if.master         fif,
    output logic                       halted,
    output logic                       err,
    output logic [1:0]                 fsmState
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } stateE;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    stateE       state;
    stateE       stateNext;
    logic        kill;
    logic        killNext;
    logic [15:0] pcReg;
    logic [15:0] pcNext;
    logic        loadSlot;
    logic        slotFree;
    logic        accept;

    // Slot may take a new fetch if it is empty or being consumed this edge.
    assign slotFree      = !fif.valid_out || !fif.id_stall;
    assign fif.imem_req  = rst && (state == ISSUE) && !fif.redirect && slotFree;
    assign fif.imem_addr = pcReg;
    assign accept        = fif.imem_req && !fif.imem_stall;

    assign halted   = (state == HALT);
    assign fsmState = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ISSUE;
            kill  <= 1'b0;
            pcReg <= RESET_PC;
        end else begin
            state <= stateNext;
            kill  <= killNext;
            pcReg <= pcNext;
        end
    end

    always_comb begin
        stateNext = state;
        killNext  = kill;
        pcNext    = pcReg;
        loadSlot  = 1'b0;
        if (fif.redirect) begin
            pcNext = {fif.redirect_pc[15:1], 1'b0};
            // An in-flight response not yet returned must be swallowed when it arrives.
            if (state == WAIT && !fif.imem_done) begin
                stateNext = WAIT;
                killNext  = 1'b1;
            end else begin
                stateNext = ISSUE;
                killNext  = 1'b0;
            end
        end else begin
            case (state)
                ISSUE: begin
                    if (accept) stateNext = WAIT;
                end
                WAIT: begin
                    if (fif.imem_done) begin
                        killNext = 1'b0;
                        if (kill) begin
                            stateNext = ISSUE;
                        end else begin
                            loadSlot  = 1'b1;
                            pcNext    = pcReg + PC_INC;
                            stateNext = (fif.imem_rdata[15:11] == HALT_OPCODE) ? HALT : ISSUE;
                        end
                    end
                end
                HALT: begin
                    stateNext = HALT;
                end
                default: begin
                    stateNext = ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fif.valid_out   <= 1'b0;
            fif.instr_out   <= NOP_INSTR;
            fif.pc_out      <= 16'h0000;
            fif.pc_next_out <= 16'h0000;
        end else if (fif.redirect) begin
            fif.valid_out <= 1'b0;
        end else if (loadSlot) begin
            fif.valid_out   <= 1'b1;
            fif.instr_out   <= fif.imem_rdata;
            fif.pc_out      <= pcReg;
            fif.pc_next_out <= pcReg + PC_INC;
        end else if (!fif.id_stall) begin
            fif.valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (fif.redirect && fif.redirect_pc[0]) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: a small imem responder driven cycle by cycle,
// one task per scenario with inline checks against hand-computed values.
module tb_fetch_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        halted;
    logic        err;
    logic [1:0]  fsmState;

    fetch_stage_ctrl_if fif();

    fetch_stage_ctrl #(
        .RESET_PC(16'h0000),
        .PC_INC(16'd2),
        .HALT_OPCODE(5'b00000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fif(fif),
        .halted(halted),
        .err(err),
        .fsmState(fsmState)
    );

    int passCnt  = 0;
    int totalCnt = 0;

    logic [15:0] respQ[$];
    logic [15:0] accQ[$];
    logic [15:0] exp_q[$];
    int          memDelay;
    int          pendCnt;
    logic [15:0] pendData;

    logic        sReq;
    logic        sValid;
    logic        sHalted;
    logic        sErr;
    logic [15:0] sAddr;
    logic [15:0] sInstr;
    logic [15:0] sPc;
    logic [15:0] sPcNext;

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        fif.imem_stall  = 1'b0;
        fif.imem_done   = 1'b0;
        fif.imem_rdata  = 16'h0000;
        fif.id_stall    = 1'b0;
        fif.redirect    = 1'b0;
        fif.redirect_pc = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        respQ.delete();
        accQ.delete();
        memDelay = 0;
        pendCnt  = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Called just after a negedge with this cycle's inputs driven. Samples outputs,
    // models the memory (done arrives memDelay cycles after the cycle following an accept),
    // then advances to the next negedge and drives the response.
    task automatic cycle();
        #2;
        sReq    = fif.imem_req;
        sAddr   = fif.imem_addr;
        sValid  = fif.valid_out;
        sInstr  = fif.instr_out;
        sPc     = fif.pc_out;
        sPcNext = fif.pc_next_out;
        sHalted = halted;
        sErr    = err;
        if (sReq && !fif.imem_stall) begin
            accQ.push_back(sAddr);
            pendCnt = memDelay;
            if (respQ.size() > 0) pendData = respQ.pop_front();
            else                  pendData = 16'h0800;
        end else if (pendCnt > 0) begin
            pendCnt--;
        end
        @(negedge clk);
        if (pendCnt == 0) begin
            fif.imem_done  = 1'b1;
            fif.imem_rdata = pendData;
            pendCnt        = -1;
        end else begin
            fif.imem_done  = 1'b0;
            fif.imem_rdata = 16'h0000;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        #2;
        totalCnt++; if (fif.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", fif.imem_req); else passCnt++;
        totalCnt++; if (fif.valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", fif.valid_out); else passCnt++;
        totalCnt++; if (fif.instr_out !== 16'h0800) $display("FAIL reset_instr: got %h want 0800", fif.instr_out); else passCnt++;
        totalCnt++; if ({fif.pc_out, fif.pc_next_out} !== 32'h0) $display("FAIL reset_pc: got %h/%h want 0000/0000", fif.pc_out, fif.pc_next_out); else passCnt++;
        totalCnt++; if ({halted, err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {halted, err}); else passCnt++;
        totalCnt++; if (fsmState !== 2'd0) $display("FAIL reset_state: got %0d want 0", fsmState); else passCnt++;
        totalCnt++; if (fif.imem_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", fif.imem_addr); else passCnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] expInstr;
        do_reset();
        respQ.push_back(16'h4000); respQ.push_back(16'h4001); respQ.push_back(16'h4002);
        exp_q.delete();
        exp_q.push_back(16'h4000); exp_q.push_back(16'h4001); exp_q.push_back(16'h4002);
        for (int k = 0; k < 3; k++) begin
            cycle();
            totalCnt++; if ({sReq, sAddr} !== {1'b1, 16'(2 * k)}) $display("FAIL seq_req_addr: got %b/%h want 1/%h", sReq, sAddr, 16'(2 * k)); else passCnt++;
            totalCnt++; if (sValid !== (k > 0)) $display("FAIL seq_valid: got %b want %b", sValid, (k > 0)); else passCnt++;
            if (k > 0) begin
                expInstr = exp_q.pop_front();
                totalCnt++; if ({sInstr, sPc, sPcNext} !== {expInstr, 16'(2 * k - 2), 16'(2 * k)}) $display("FAIL seq_slot: got %h/%h/%h want %h/%h/%h", sInstr, sPc, sPcNext, expInstr, 16'(2 * k - 2), 16'(2 * k)); else passCnt++;
            end
            cycle();
            totalCnt++; if ({sReq, sValid} !== 2'b00) $display("FAIL seq_wait: got req/valid %b want 00", {sReq, sValid}); else passCnt++;
        end
        cycle();
        expInstr = exp_q.pop_front();
        totalCnt++; if ({sValid, sInstr, sPc, sPcNext} !== {1'b1, expInstr, 16'h0004, 16'h0006}) $display("FAIL seq_last: got %b/%h/%h/%h want 1/%h/0004/0006", sValid, sInstr, sPc, sPcNext, expInstr); else passCnt++;
    endtask

    task automatic test_imem_stall();
        do_reset();
        respQ.push_back(16'h4321);
        for (int k = 0; k < 4; k++) begin
            fif.imem_stall = (k < 3);
            cycle();
            totalCnt++; if ({sReq, sAddr} !== {1'b1, 16'h0000}) $display("FAIL stall_hold: got %b/%h want 1/0000", sReq, sAddr); else passCnt++;
        end
        totalCnt++; if (accQ.size() !== 1) $display("FAIL stall_accepts: got %0d want 1", accQ.size()); else passCnt++;
        cycle();
        totalCnt++; if ({sReq, sValid} !== 2'b00) $display("FAIL stall_wait: got %b want 00", {sReq, sValid}); else passCnt++;
        cycle();
        totalCnt++; if ({sValid, sInstr, sPc} !== {1'b1, 16'h4321, 16'h0000}) $display("FAIL stall_slot: got %b/%h/%h want 1/4321/0000", sValid, sInstr, sPc); else passCnt++;
        totalCnt++; if ({sReq, sAddr} !== {1'b1, 16'h0002}) $display("FAIL stall_next_req: got %b/%h want 1/0002", sReq, sAddr); else passCnt++;
        cycle();
        totalCnt++; if (sValid !== 1'b0) $display("FAIL stall_no_dup: got %b want 0", sValid); else passCnt++;
        cycle();
        totalCnt++; if ({sValid, sInstr, sPc} !== {1'b1, 16'h0800, 16'h0002}) $display("FAIL stall_second: got %b/%h/%h want 1/0800/0002", sValid, sInstr, sPc); else passCnt++;
    endtask

    task automatic test_id_stall();
        do_reset();
        respQ.push_back(16'h1234);
        cycle();
        cycle();
        fif.id_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            totalCnt++; if ({sValid, sInstr, sPc} !== {1'b1, 16'h1234, 16'h0000}) $display("FAIL idstall_hold: got %b/%h/%h want 1/1234/0000", sValid, sInstr, sPc); else passCnt++;
            totalCnt++; if (sReq !== 1'b0) $display("FAIL idstall_noreq: got %b want 0", sReq); else passCnt++;
        end
        fif.id_stall = 1'b0;
        cycle();
        totalCnt++; if ({sValid, sInstr, sReq, sAddr} !== {1'b1, 16'h1234, 1'b1, 16'h0002}) $display("FAIL idstall_release: got %b/%h/%b/%h want 1/1234/1/0002", sValid, sInstr, sReq, sAddr); else passCnt++;
        cycle();
        totalCnt++; if (sValid !== 1'b0) $display("FAIL idstall_consumed: got %b want 0", sValid); else passCnt++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        memDelay = 2;
        respQ.push_back(16'hBEEF);
        cycle();
        totalCnt++; if ({sReq, sAddr} !== {1'b1, 16'h0000}) $display("FAIL redir_first_req: got %b/%h want 1/0000", sReq, sAddr); else passCnt++;
        fif.redirect = 1'b1; fif.redirect_pc = 16'h0100;
        cycle();
        totalCnt++; if (sReq !== 1'b0) $display("FAIL redir_cycle_req: got %b want 0", sReq); else passCnt++;
        fif.redirect = 1'b0;
        cycle();
        totalCnt++; if ({sReq, sValid} !== 2'b00) $display("FAIL redir_killwait: got %b want 00", {sReq, sValid}); else passCnt++;
        cycle();
        totalCnt++; if ({sReq, sValid} !== 2'b00) $display("FAIL redir_drop: got %b want 00", {sReq, sValid}); else passCnt++;
        memDelay = 0;
        respQ.push_back(16'h4444);
        cycle();
        totalCnt++; if ({sReq, sAddr, sValid} !== {1'b1, 16'h0100, 1'b0}) $display("FAIL redir_new_req: got %b/%h/%b want 1/0100/0", sReq, sAddr, sValid); else passCnt++;
        cycle();
        totalCnt++; if (sValid !== 1'b0) $display("FAIL redir_new_wait: got %b want 0", sValid); else passCnt++;
        cycle();
        totalCnt++; if ({sValid, sInstr, sPc, sPcNext} !== {1'b1, 16'h4444, 16'h0100, 16'h0102}) $display("FAIL redir_new_slot: got %b/%h/%h/%h want 1/4444/0100/0102", sValid, sInstr, sPc, sPcNext); else passCnt++;
    endtask

    task automatic test_halt();
        do_reset();
        fif.redirect = 1'b1; fif.redirect_pc = 16'h0010;
        cycle();
        totalCnt++; if (sReq !== 1'b0) $display("FAIL halt_redir_req: got %b want 0", sReq); else passCnt++;
        fif.redirect = 1'b0;
        respQ.push_back(16'h0000);
        cycle();
        totalCnt++; if ({sReq, sAddr} !== {1'b1, 16'h0010}) $display("FAIL halt_fetch_req: got %b/%h want 1/0010", sReq, sAddr); else passCnt++;
        cycle();
        cycle();
        totalCnt++; if ({sValid, sInstr, sPc, sHalted, sReq} !== {1'b1, 16'h0000, 16'h0010, 1'b1, 1'b0}) $display("FAIL halt_slot: got %b/%h/%h/%b/%b want 1/0000/0010/1/0", sValid, sInstr, sPc, sHalted, sReq); else passCnt++;
        for (int k = 0; k < 3; k++) begin
            cycle();
            totalCnt++; if ({sReq, sHalted, sValid} !== 3'b010) $display("FAIL halt_idle: got req/halted/valid %b want 010", {sReq, sHalted, sValid}); else passCnt++;
        end
        fif.redirect = 1'b1; fif.redirect_pc = 16'h0020;
        cycle();
        totalCnt++; if ({sReq, sHalted} !== 2'b01) $display("FAIL halt_exit_cycle: got %b want 01", {sReq, sHalted}); else passCnt++;
        fif.redirect = 1'b0;
        cycle();
        totalCnt++; if ({sHalted, sReq, sAddr} !== {1'b0, 1'b1, 16'h0020}) $display("FAIL halt_resume: got %b/%b/%h want 0/1/0020", sHalted, sReq, sAddr); else passCnt++;
    endtask

    task automatic test_misaligned_wrap();
        do_reset();
        fif.redirect = 1'b1; fif.redirect_pc = 16'h0101;
        cycle();
        totalCnt++; if (sErr !== 1'b0) $display("FAIL mis_err_before: got %b want 0", sErr); else passCnt++;
        fif.redirect = 1'b0;
        cycle();
        totalCnt++; if ({sErr, sReq, sAddr} !== {1'b1, 1'b1, 16'h0100}) $display("FAIL mis_aligned_req: got %b/%b/%h want 1/1/0100", sErr, sReq, sAddr); else passCnt++;
        cycle();
        fif.redirect = 1'b1; fif.redirect_pc = 16'hFFFE;
        cycle();
        totalCnt++; if ({sValid, sPc, sReq, sErr} !== {1'b1, 16'h0100, 1'b0, 1'b1}) $display("FAIL mis_slot: got %b/%h/%b/%b want 1/0100/0/1", sValid, sPc, sReq, sErr); else passCnt++;
        fif.redirect = 1'b0;
        cycle();
        totalCnt++; if ({sReq, sAddr, sValid} !== {1'b1, 16'hFFFE, 1'b0}) $display("FAIL wrap_req: got %b/%h/%b want 1/fffe/0", sReq, sAddr, sValid); else passCnt++;
        cycle();
        cycle();
        totalCnt++; if ({sValid, sPc, sPcNext} !== {1'b1, 16'hFFFE, 16'h0000}) $display("FAIL wrap_slot: got %b/%h/%h want 1/fffe/0000", sValid, sPc, sPcNext); else passCnt++;
        totalCnt++; if ({sReq, sAddr, sErr} !== {1'b1, 16'h0000, 1'b1}) $display("FAIL wrap_next_req: got %b/%h/%b want 1/0000/1", sReq, sAddr, sErr); else passCnt++;
        rst = 1'b0;
        #2;
        totalCnt++; if (err !== 1'b0) $display("FAIL err_cleared_by_reset: got %b want 0", err); else passCnt++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        respQ.push_back(16'h5555);
        cycle();
        rst = 1'b0;
        #2;
        totalCnt++; if ({fsmState, fif.valid_out} !== 3'b000) $display("FAIL midwait_async: got %b want 000", {fsmState, fif.valid_out}); else passCnt++;
        @(negedge clk);
        rst = 1'b1;
        pendCnt = -1;
        respQ.delete();
        respQ.push_back(16'h6666);
        fif.imem_done  = 1'b1;
        fif.imem_rdata = 16'h5555;
        cycle();
        totalCnt++; if ({sReq, sAddr, sValid} !== {1'b1, 16'h0000, 1'b0}) $display("FAIL midwait_stale: got %b/%h/%b want 1/0000/0", sReq, sAddr, sValid); else passCnt++;
        cycle();
        totalCnt++; if (sValid !== 1'b0) $display("FAIL midwait_no_stale_load: got %b/%h want 0", sValid, sInstr); else passCnt++;
        cycle();
        totalCnt++; if ({sValid, sInstr} !== {1'b1, 16'h6666}) $display("FAIL midwait_fresh: got %b/%h want 1/6666", sValid, sInstr); else passCnt++;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b0;
        drive_idle();
        memDelay = 0;
        pendCnt  = -1;
        test_reset();
        test_back_to_back();
        test_imem_stall();
        test_id_stall();
        test_redirect_wait();
        test_halt();
        test_misaligned_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
